// File: rtl/sram_lat.sv
// sram_lat: single-port synchronous SRAM with byte-masked writes, a
// configurable read pipeline (RD_LAT = 1..4), a read-valid strobe and a
// zeroing sweep that runs after reset (CLR_ON_RST) or on clr_i.
//
// Ports:
//   clk_i, rst_n_i     clock, asynchronous active-low reset
//   en_i, wen_i        access request, 1 = write / 0 = read
//   bm_i               per-byte write enable
//   addr_i, dat_i      word address and write data
//   dat_o, rvalid_o    read data and its one-cycle valid strobe
//   ready_o            high while accesses are accepted (not sweeping)
//   clr_i              start a clear sweep (ignored while one is running)
module sram_lat #(
    parameter int BIT_WIDTH  = 64,
    parameter int WORD_DEPTH = 512,
    parameter int RD_LAT     = 1,
    parameter bit CLR_ON_RST = 1'b1,
    localparam int AW = (WORD_DEPTH > 1) ? $clog2(WORD_DEPTH) : 1,
    localparam int NB = BIT_WIDTH / 8
) (
    input  logic                 clk_i,
    input  logic                 rst_n_i,
    input  logic                 en_i,
    input  logic                 wen_i,
    input  logic [NB-1:0]        bm_i,
    input  logic [AW-1:0]        addr_i,
    input  logic [BIT_WIDTH-1:0] dat_i,
    output logic [BIT_WIDTH-1:0] dat_o,
    output logic                 rvalid_o,
    output logic                 ready_o,
    input  logic                 clr_i
);

    localparam logic [0:0]    ST_INIT   = 1'b0;
    localparam logic [0:0]    ST_READY  = 1'b1;
    // One extra bit so WORD_DEPTH itself is representable for the range test.
    localparam logic [AW:0]   DEPTH_EXT = (AW+1)'(WORD_DEPTH);
    localparam logic [AW-1:0] LAST_ADDR = AW'(WORD_DEPTH - 1);

    logic [BIT_WIDTH-1:0] mem [WORD_DEPTH];

    logic [0:0]           state;
    logic [AW-1:0]        clr_addr;
    logic                 in_range;
    logic                 acc;
    logic                 rd_acc;
    logic [BIT_WIDTH-1:0] rd_word;

    // Stage s holds a read accepted s+1 edges ago; the last stage is the output.
    logic [RD_LAT-1:0]    vld_pipe;
    logic [BIT_WIDTH-1:0] dat_pipe [RD_LAT];

    assign ready_o  = (state == ST_READY);
    assign in_range = ({1'b0, addr_i} < DEPTH_EXT);
    assign acc      = en_i & ready_o;
    assign rd_acc   = acc & ~wen_i;
    // Asynchronous array read: returns the word as it stands before the edge,
    // so a same-edge write is not visible to this read.
    assign rd_word  = in_range ? mem[addr_i] : '0;

    // Sweep / ready state machine.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state    <= CLR_ON_RST ? ST_INIT : ST_READY;
            clr_addr <= '0;
        end else begin
            case (state)
                ST_INIT: begin
                    if (clr_addr == LAST_ADDR) begin
                        state    <= ST_READY;
                        clr_addr <= '0;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                ST_READY: begin
                    if (clr_i) begin
                        state    <= ST_INIT;
                        clr_addr <= '0;
                    end
                end
                default: state <= ST_READY;
            endcase
        end
    end

    // Storage has no reset; only the sweep zeroes it. Accesses are never
    // accepted during INIT, so the two write sources never collide.
    always_ff @(posedge clk_i) begin
        if (state == ST_INIT) begin
            mem[clr_addr] <= '0;
        end else if (acc && wen_i && in_range) begin
            for (int b = 0; b < NB; b++) begin
                if (bm_i[b]) mem[addr_i][8*b +: 8] <= dat_i[8*b +: 8];
            end
        end
    end

    // Read pipeline. Data registers load only behind a valid bit, so the
    // final stage keeps the last delivered word while rvalid_o is low.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_pipe <= '0;
            for (int s = 0; s < RD_LAT; s++) dat_pipe[s] <= '0;
        end else begin
            vld_pipe[0] <= rd_acc;
            if (rd_acc) dat_pipe[0] <= rd_word;
            for (int s = 1; s < RD_LAT; s++) begin
                vld_pipe[s] <= vld_pipe[s-1];
                if (vld_pipe[s-1]) dat_pipe[s] <= dat_pipe[s-1];
            end
        end
    end

    assign rvalid_o = vld_pipe[RD_LAT-1];
    assign dat_o    = dat_pipe[RD_LAT-1];

endmodule

// File: tb/tb_sram_lat.sv
// tb_sram_lat: four sram_lat instances (RD_LAT 1..4, WORD_DEPTH 12) share one
// stimulus stream. A reference model (plain array + sweep countdown) predicts
// ready and read data; reads are appended to a shared list with their accept
// edge, and each instance's monitor walks that list, checking data, arrival
// edge, output hold and unexpected/missing strobes.
module tb_sram_lat;

    localparam int DEPTH = 12;
    localparam int NI    = 4;

    logic                clk = 1'b0;
    logic                rst_n;
    logic                en, wen, clr;
    logic [7:0]          bm;
    logic [3:0]          addr;
    logic [63:0]         dat;
    logic [NI-1:0]       rvalid_w, ready_w;
    logic [NI-1:0][63:0] dat_w;

    int pass_cnt  = 0;
    int total_cnt = 0;
    int edge_cnt  = 0;

    // Reference model
    logic [63:0] mem_m [16];
    int          init_left;
    logic [63:0] rd_dat  [$];
    int          rd_edge [$];

    always #5 clk = ~clk;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] want);
        total_cnt++;
        if (act === want) pass_cnt++;
        else $display("FAIL %s: got %h want %h (edge %0d)", nm, act, want, edge_cnt);
    endtask

    task automatic bad(input string nm);
        total_cnt++;
        $display("FAIL %s (edge %0d)", nm, edge_cnt);
    endtask

    for (genvar i = 0; i < NI; i++) begin : g_dut
        localparam int L = i + 1;

        sram_lat #(
            .BIT_WIDTH (64),
            .WORD_DEPTH(DEPTH),
            .RD_LAT    (L),
            .CLR_ON_RST(1'b1)
        ) u_dut (
            .clk_i   (clk),
            .rst_n_i (rst_n),
            .en_i    (en),
            .wen_i   (wen),
            .bm_i    (bm),
            .addr_i  (addr),
            .dat_i   (dat),
            .dat_o   (dat_w[i]),
            .rvalid_o(rvalid_w[i]),
            .ready_o (ready_w[i]),
            .clr_i   (clr)
        );

        initial begin : mon
            int          ptr;
            logic [63:0] last;
            ptr  = 0;
            last = '0;
            forever begin
                @(negedge clk);
                if (!rst_n) begin
                    // Reads still in flight at reset are never delivered.
                    ptr  = rd_dat.size();
                    last = '0;
                    chk($sformatf("rst_rvalid_L%0d", L), 64'(rvalid_w[i]), 64'd0);
                    chk($sformatf("rst_dat_L%0d", L), dat_w[i], 64'd0);
                end else if (rvalid_w[i]) begin
                    if (ptr >= rd_dat.size()) begin
                        bad($sformatf("unexpected_rvalid_L%0d", L));
                    end else begin
                        chk($sformatf("rdata_L%0d", L), dat_w[i], rd_dat[ptr]);
                        chk($sformatf("rlat_L%0d", L), 64'(edge_cnt), 64'(rd_edge[ptr] + L - 1));
                        last = dat_w[i];
                        ptr++;
                    end
                end else begin
                    chk($sformatf("hold_L%0d", L), dat_w[i], last);
                    if (ptr < rd_dat.size() && rd_edge[ptr] + L - 1 < edge_cnt) begin
                        bad($sformatf("missed_rvalid_L%0d", L));
                        ptr++;
                    end
                end
            end
        end
    end

    task automatic zero_model();
        for (int a = 0; a < 16; a++) mem_m[a] = '0;
    endtask

    // Called at a falling edge: applies inputs, advances the model across the
    // next rising edge, returns at the following falling edge.
    task automatic drive(input logic e, input logic w, input logic [7:0] m,
                         input logic [3:0] a, input logic [63:0] d, input logic c);
        logic rdy;
        en = e; wen = w; bm = m; addr = a; dat = d; clr = c;
        rdy = (init_left == 0);
        chk("ready", 64'(ready_w), rdy ? 64'hF : 64'h0);
        if (rdy) begin
            if (e && !w) begin
                rd_dat.push_back((a < DEPTH) ? mem_m[a] : 64'd0);
                rd_edge.push_back(edge_cnt + 1);
            end
            if (e && w && a < DEPTH) begin
                for (int b = 0; b < 8; b++)
                    if (m[b]) mem_m[a][8*b +: 8] = d[8*b +: 8];
            end
            if (c) begin
                zero_model();
                init_left = DEPTH;
            end
        end else begin
            init_left--;
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wr(input logic [3:0] a, input logic [63:0] d, input logic [7:0] m);
        drive(1'b1, 1'b1, m, a, d, 1'b0);
    endtask

    task automatic rd(input logic [3:0] a);
        drive(1'b1, 1'b0, 8'($urandom), a, 64'd0, 1'b0);
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 8'h00, 4'd0, 64'd0, 1'b0);
    endtask

    // Random requests while sweeping: all must be ignored, including clr_i.
    task automatic noise_during_sweep();
        while (init_left > 0)
            drive(1'($urandom), 1'($urandom), 8'($urandom), 4'($urandom),
                  {$urandom, $urandom}, 1'($urandom));
    endtask

    task automatic release_reset();
        rst_n     = 1'b1;
        init_left = DEPTH;
        zero_model();
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; wen = 1'b0; clr = 1'b0;
        bm = '0; addr = '0; dat = '0;
        init_left = 0;
        zero_model();
        repeat (2) @(negedge clk);
        chk("rst_ready", 64'(ready_w), 64'h0);
        release_reset();

        // Post-reset sweep: ready low for exactly DEPTH edges, then all zero.
        noise_during_sweep();
        for (int a = 0; a < DEPTH; a++) rd(4'(a));

        // Byte mask
        wr(4'd5, 64'h1122334455667788, 8'hFF);
        wr(4'd5, 64'hAAAAAAAAAAAAAAAA, 8'h0F);
        rd(4'd5);

        // Back-to-back reads across all latencies
        for (int a = 0; a < 8; a++) wr(4'(a), 64'(a * 3), 8'hFF);
        for (int a = 0; a < 8; a++) rd(4'(a));

        // Write then read next cycle; zero mask is a no-op
        wr(4'd3, 64'hDEAD, 8'hFF);
        rd(4'd3);
        wr(4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00);
        rd(4'd3);

        // Out-of-range: read returns 0, write lands nowhere
        rd(4'd13);
        wr(4'd13, 64'hCAFE_F00D_1234_5678, 8'hFF);
        rd(4'd12);
        for (int a = 0; a < DEPTH; a++) rd(4'(a));

        // Random traffic
        for (int n = 0; n < 300; n++)
            drive(($urandom % 4) != 0, 1'($urandom), ($urandom % 8 == 0) ? 8'h00 : 8'($urandom),
                  4'($urandom), {$urandom, $urandom}, 1'b0);

        // Commanded clear with a same-cycle read
        wr(4'd2, 64'h55, 8'hFF);
        drive(1'b1, 1'b0, 8'h00, 4'd2, 64'd0, 1'b1);
        noise_during_sweep();
        rd(4'd2);

        // Commanded clear with a same-cycle write: sweep overwrites it
        wr(4'd7, 64'h77, 8'hFF);
        drive(1'b1, 1'b1, 8'hFF, 4'd7, 64'h1234, 1'b1);
        noise_during_sweep();
        rd(4'd7);
        rd(4'd2);

        // Reset one cycle after a read
        wr(4'd9, 64'h9999_0000_9999_0001, 8'hFF);
        rd(4'd9);
        idle();
        #2 rst_n = 1'b0;
        en = 1'b0; clr = 1'b0;
        #1;
        chk("midrst_rvalid", 64'(rvalid_w), 64'h0);
        chk("midrst_dat", {dat_w[3] | dat_w[2], dat_w[1] | dat_w[0]}, 64'h0);
        chk("midrst_ready", 64'(ready_w), 64'h0);
        repeat (3) @(negedge clk);
        release_reset();
        noise_during_sweep();
        rd(4'd9);
        rd(4'd5);

        repeat (8) idle();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/sram_lat.md
# sram_lat

Parametrised single-port synchronous SRAM with byte-masked writes, configurable read latency, a read-valid strobe and a built-in clear sweep. It is the behavioural and FPGA-inferable memory behind the `sram_if` dut modport. It extends that contract with `rvalid_o`, `ready_o` and `clr_i` for pipelined consumers, such as cache data arrays, that need multi-cycle read paths and a known-zero memory after reset.

## Interface
Parameters:
- `BIT_WIDTH`, default 64: data width; must be a multiple of 8.
- `WORD_DEPTH`, default 512: number of words; need not be a power of 2.
- `RD_LAT`, default 1: read latency in cycles; legal range 1..4.
- `CLR_ON_RST`, default 1: 1 = clear sweep runs automatically after reset.

Ports:
- `clk_i`  in  1  clock.
- `rst_n_i`  in  1  asynchronous, active-low reset.
- `en_i`  in  1  access request.
- `wen_i`  in  1  1 = write, 0 = read; qualified by `en_i`.
- `bm_i`  in  BIT_WIDTH/8  byte mask for writes; bit b enables byte b.
- `addr_i`  in  $clog2(WORD_DEPTH)  word address.
- `dat_i`  in  BIT_WIDTH  write data.
- `dat_o`  out  BIT_WIDTH  read data.
- `rvalid_o`  out  1  `dat_o` carries read data this cycle.
- `ready_o`  out  1  accepting accesses (state READY).
- `clr_i`  in  1  start a clear sweep.

## Operation
- **State machine:** two states, INIT and READY.
  - Reset enters INIT if `CLR_ON_RST=1`, otherwise READY.
  - INIT: a counter `clr_addr` runs 0..WORD_DEPTH-1 and writes all-zero, one word per cycle. After word WORD_DEPTH-1 the state goes to READY.
  - READY: `clr_i=1` moves to INIT with `clr_addr=0`.
  - `clr_i` is ignored in INIT; the sweep is not restarted.
  - `ready_o = (state==READY)`, decoded directly from the state register.
- **Accept rule:** an access is accepted when `en_i & ready_o` at a rising edge. When `ready_o=0`, `en_i` is ignored: no write, no `rvalid_o`.
- **Write** (`en_i & wen_i`, accepted):
  - For each b with `bm_i[b]=1`, `mem[addr_i][8b+7:8b]` takes `dat_i[8b+7:8b]` at the edge.
  - Bytes with `bm_i[b]=0` are unchanged. `bm_i=0` is a legal no-op write.
- **Read** (`en_i & ~wen_i`, accepted):
  - Samples `mem[addr_i]` as it stands before that edge.
  - The data passes through an RD_LAT-stage pipeline, each stage carrying valid and data.
  - `bm_i` is ignored for reads.
- **Out-of-range address** (`addr_i >= WORD_DEPTH`): a write is dropped; a read returns all-zero, with `rvalid_o` still asserted.
- **Read after write:** a read of the same address one or more cycles after a write returns the new data. Back-to-back accesses are supported every cycle.
- **Output hold:** `dat_o` holds the last delivered read data while `rvalid_o=0`.
- **Clear overlapping traffic:**
  - Reads in flight when INIT begins still complete, with their sampled data.
  - An access accepted in the same cycle that `clr_i` is sampled is performed. The sweep then overwrites it.
- **Reset mid-operation:**
  - The pipeline, state and counter are reset; `dat_o=0` and `rvalid_o=0`.
  - Memory contents are not reset directly; only the sweep clears them.

## Timing
- **Reset values:**
  - `dat_o=0` and `rvalid_o=0`.
  - `ready_o=0` if `CLR_ON_RST=1`, else 1.
  - `clr_addr=0`.
- **Read latency:** a read accepted at edge k gives `rvalid_o=1` and valid `dat_o` after edge k+RD_LAT-1. Sampling happens at edge k+RD_LAT; `rvalid_o` is high for exactly one cycle per read.
- **Post-reset sweep:** with `CLR_ON_RST=1`, `ready_o` rises after exactly WORD_DEPTH rising edges following reset release.
- **Commanded sweep:** `clr_i` sampled at edge k drops `ready_o` after edge k. `ready_o` returns high after edge k+WORD_DEPTH.
- **Throughput:** 1 access per cycle; no stalls while READY.

## Test plan
- **Reset clear:** `CLR_ON_RST=1`, WORD_DEPTH=16. Release reset and read all 16 addresses.
  - `ready_o` is 0 for 16 cycles, then 1.
  - Every read returns 0 with `rvalid_o` exactly RD_LAT cycles later.
- **Byte mask:**
  - Write 0x1122334455667788 to addr 5 with `bm_i=0xFF`.
  - Write 0xAAAAAAAAAAAAAAAA to addr 5 with `bm_i=0x0F`.
  - Read addr 5: returns 0x11223344AAAAAAAA.
- **Latency sweep:** for RD_LAT 1..4, issue 8 back-to-back reads of addrs 0..7, each pre-written with value addr·3.
  - 8 consecutive `rvalid_o` pulses start RD_LAT cycles after the first read.
  - Data arrives in order.
- **Write then read:** write 0xDEAD to addr 3 at edge k, read addr 3 at edge k+1 → returns 0xDEAD.
  - Separately, with WORD_DEPTH=12, read addr 13 → 0 with `rvalid_o=1`, and a write to addr 13 changes no word.
- **Commanded clear:** in READY, issue a read of addr 2 (holding 0x55) and assert `clr_i` in the same cycle.
  - The read returns 0x55 with `rvalid_o`.
  - `ready_o` is low for WORD_DEPTH cycles; `en_i` pulses during that window produce no `rvalid_o`.
  - A read of addr 2 afterwards returns 0.
- **Reset mid-read:** with RD_LAT=3, assert `rst_n_i` low one cycle after a read.
  - `rvalid_o` and `dat_o` go to 0 immediately; no `rvalid_o` pulse appears after reset release.
